// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t     : responder FSM states
//   BYTE_LANES  : byte enables per data word
//   WORD_BYTES  : bytes per data word
//   WAIT_W      : width of the wait-state counter (WAIT_CYCLES 0..15)
package mem_if_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int BYTE_LANES = 4;
  localparam int WORD_BYTES = 4;
  localparam int WAIT_W     = 4;
endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage with byte-enable write and synchronous read on one port.
//   clk   : clock
//   en    : access strobe, pulsed on the commit edge only
//   we    : 1 = write the enabled bytes, 0 = read into rdata
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   idx   : word index
//   wdata : write data
//   rdata : read data, updated only by a read access
module dmem_bank
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  // No reset: contents survive a responder reset.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the CPU data-memory port. Accepts one
// request at a time, waits WAIT_CYCLES, commits the access, then holds the
// response until the initiator takes it.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake
//   req_we/addr/wdata/be  : request payload (sampled on the accept edge only)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_err    : read data (0 for writes/errors), access error
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | request latched, counting wait states; commit when counter is 0
// RESP  | response presented, waiting for rsp_ready
module dmem_responder
  import mem_if_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state, state_nx;
  logic [WAIT_W-1:0] cnt;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;
  logic              err_q;
  logic              rd_ok;
  logic              accept;
  logic              commit;
  logic [31:0]       off;
  logic              addr_err;
  logic [31:0]       bank_rdata;

  // Addresses below ADDR_BASE wrap to huge offsets and so fall out of range.
  assign off      = lat_addr - ADDR_BASE;
  assign addr_err = (lat_addr[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH));

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          commit   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      err_q     <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= WAIT_W'(WAIT_CYCLES);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        err_q <= addr_err;
        rd_ok <= !lat_we && !addr_err;
      end
    end
  end

  dmem_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank (
    .clk   (clk),
    .en    (commit && !addr_err),
    .we    (lat_we),
    .be    (lat_be),
    .idx   (off[IDX_W+1:2]),
    .wdata (lat_wdata),
    .rdata (bank_rdata)
  );

  // The bank read register only changes on a read commit, so it is stable
  // for the whole of RESP; gating keeps writes, errors and idle at zero.
  assign rsp_rdata = (state == RESP && rd_ok) ? bank_rdata : 32'h0;
  assign rsp_err   = (state == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam int          WAIT0 = 2;
  localparam int          WAIT1 = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b0;

  logic        rrdy0, rval0, rerr0, rrdy1, rval1, rerr1;
  logic [31:0] rdat0, rdat1;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT0), .ADDR_BASE(BASE0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel), .req_ready(rrdy0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rval0), .rsp_ready(rsp_ready && !sel),
    .rsp_rdata(rdat0), .rsp_err(rerr0)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT1), .ADDR_BASE(BASE1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel), .req_ready(rrdy1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rval1), .rsp_ready(rsp_ready && sel),
    .rsp_rdata(rdat1), .rsp_err(rerr1)
  );

  assign o_req_ready = sel ? rrdy1 : rrdy0;
  assign o_rsp_valid = sel ? rval1 : rval0;
  assign o_rsp_rdata = sel ? rdat1 : rdat0;
  assign o_rsp_err   = sel ? rerr1 : rerr0;

  // Reference model: word-addressed array updated per transaction.
  function automatic void model(input int s, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] exp_rd, output bit exp_err);
    logic [31:0] off;
    longint unsigned widx;
    off = addr - (s == 1 ? BASE1 : BASE0);
    widx = longint'(off) / 4;
    exp_err = (addr % 4 != 0) || (widx >= DEPTH);
    exp_rd = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[s][widx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rd = mdl[s][widx];
      end
    end
  endfunction

  function automatic logic [31:0] gen_addr(input int s);
    logic [31:0] base;
    int r;
    base = (s == 1) ? BASE1 : BASE0;
    r = $urandom_range(0, 9);
    if (r <= 6) return base + 32'(4 * $urandom_range(0, DEPTH - 1));
    if (r == 7) return base + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
    if (r == 8) return base + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
    return base - 32'(4 * $urandom_range(1, 8));
  endfunction

  // Drives one full transaction and reports what was observed.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output bit post_ok, output bit tmo);
    int n;
    tmo = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    n = 0;
    while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) tmo = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!o_rsp_valid && lat < 50);
    if (!o_rsp_valid) tmo = 1'b1;
    rd = o_rsp_rdata;
    er = o_rsp_err;
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    post_ok = o_req_ready && !o_rsp_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rrdy0 !== 1'b1) begin errors++; $display("FAIL reset_req_ready0 got=%b exp=1", rrdy0); end
    checks++; if (rval0 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid0 got=%b exp=0", rval0); end
    checks++; if (rdat0 !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata0 got=%h exp=0", rdat0); end
    checks++; if (rerr0 !== 1'b0) begin errors++; $display("FAIL reset_rsp_err0 got=%b exp=0", rerr0); end
    checks++; if (rrdy1 !== 1'b1 || rval1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 got rdy=%b val=%b exp rdy=1 val=0", rrdy1, rval1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] rd, er_rd; logic er; bit er_b; int lat; bit pok, tmo;
    sel = 1'b0;
    model(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, er_rd, er_b);
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, pok, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL basic_wr_timeout got=timeout exp=response"); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL basic_wr_rsp got err=%b rd=%h exp err=0 rd=0", er, rd); end
    checks++; if (lat !== WAIT0 + 1) begin errors++; $display("FAIL basic_wr_latency got=%0d exp=%0d", lat, WAIT0 + 1); end
    checks++; if (!pok) begin errors++; $display("FAIL basic_wr_return got=not_idle exp=idle"); end
    model(0, 1'b0, 32'h10, 32'h0, 4'h0, er_rd, er_b);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 1, rd, er, lat, pok, tmo);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL basic_rd got rd=%h err=%b exp rd=deadbeef err=0", rd, er); end
    checks++; if (lat !== WAIT0 + 1) begin errors++; $display("FAIL basic_rd_latency got=%0d exp=%0d", lat, WAIT0 + 1); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd, e_rd; logic er; bit e_er; int lat; bit pok, tmo;
    sel = 1'b0;
    model(0, 1'b1, 32'h20, 32'h11223344, 4'hF, e_rd, e_er);
    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, pok, tmo);
    model(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, e_rd, e_er);
    do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat, pok, tmo);
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL be_wr_rsp got err=%b rd=%h exp err=0 rd=0", er, rd); end
    model(0, 1'b0, 32'h20, 32'h0, 4'h0, e_rd, e_er);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, pok, tmo);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, e_rd; logic er; bit e_er; int lat; bit pok, tmo;
    sel = 1'b0;
    do_txn(1'b0, 32'h13, 32'h0, 4'hF, 0, rd, er, lat, pok, tmo);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_misaligned got err=%b rd=%h exp err=1 rd=0", er, rd); end
    do_txn(1'b0, BASE0 + 32'(4 * DEPTH), 32'h0, 4'hF, 0, rd, er, lat, pok, tmo);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_range got err=%b rd=%h exp err=1 rd=0", er, rd); end
    do_txn(1'b1, 32'h12, 32'h99999999, 4'hF, 0, rd, er, lat, pok, tmo);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_misaligned_wr got=%b exp=1", er); end
    model(0, 1'b1, 32'h10, 32'h12345678, 4'h0, e_rd, e_er);
    do_txn(1'b1, 32'h10, 32'h12345678, 4'h0, 0, rd, er, lat, pok, tmo);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_be_zero got=%b exp=0", er); end
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, pok, tmo);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL err_prior_contents got rd=%h err=%b exp rd=deadbeef err=0", rd, er); end
  endtask

  task automatic test_hold();
    int n;
    logic [31:0] rd; logic er; int lat; bit pok, tmo;
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_be = 4'hF;
    n = 0;
    while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!o_rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (!o_rsp_valid) begin errors++; $display("FAIL hold_timeout got=no_rsp exp=rsp"); end
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      req_valid = ~req_valid;
      @(posedge clk); #1;
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h11BB33DD || o_rsp_err !== 1'b0 || o_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d got val=%b rd=%h err=%b rdy=%b exp val=1 rd=11bb33dd err=0 rdy=0",
                 i, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release got rdy=%b val=%b exp rdy=1 val=0", o_req_ready, o_rsp_valid); end
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, pok, tmo);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL hold_no_second_accept got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] rd, e_rd; logic er; bit e_er; int lat; bit pok, tmo;
    sel = 1'b0;
    model(0, 1'b1, 32'h30, 32'h0, 4'hF, e_rd, e_er);
    do_txn(1'b1, 32'h30, 32'h0, 4'hF, 0, rd, er, lat, pok, tmo);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
    n = 0;
    while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid got val=%b rdy=%b exp val=0 rdy=1", o_rsp_valid, o_req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat, pok, tmo);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL rst_mid_lost_write got rd=%h err=%b exp rd=0 err=0", rd, er); end
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, pok, tmo);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_mid_persist got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_fill(input int s);
    logic [31:0] rd, e_rd, wd, a; logic er; bit e_er; int lat; bit pok, tmo;
    sel = 1'(s);
    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      a = (s == 1 ? BASE1 : BASE0) + 32'(4 * i);
      model(s, 1'b1, a, wd, 4'hF, e_rd, e_er);
      do_txn(1'b1, a, wd, 4'hF, 0, rd, er, lat, pok, tmo);
      checks++; if (tmo || er !== 1'b0) begin errors++; $display("FAIL fill%0d idx=%0d got err=%b tmo=%b exp err=0 tmo=0", s, i, er, tmo); end
    end
  endtask

  task automatic test_random(input int s, input int num);
    logic [31:0] rd, e_rd, a, wd; logic [3:0] be; logic er; bit e_er, we; int lat; bit pok, tmo;
    sel = 1'(s);
    for (int i = 0; i < num; i++) begin
      we = 1'($urandom);
      a = gen_addr(s);
      wd = $urandom;
      be = 4'($urandom);
      model(s, we, a, wd, be, e_rd, e_er);
      do_txn(we, a, wd, be, $urandom_range(0, 2), rd, er, lat, pok, tmo);
      checks++;
      if (tmo || rd !== e_rd || er !== e_er || lat !== (s == 1 ? WAIT1 : WAIT0) + 1 || !pok) begin
        errors++;
        $display("FAIL rand%0d #%0d we=%b a=%h got rd=%h err=%b lat=%0d idle=%b tmo=%b exp rd=%h err=%b lat=%0d idle=1 tmo=0",
                 s, i, we, a, rd, er, lat, pok, tmo, e_rd, e_er, (s == 1 ? WAIT1 : WAIT0) + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, e_rd, a, wd; logic er; bit e_er; int lat; bit pok, tmo;
    sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = BASE1 + 32'(4 * $urandom_range(0, DEPTH - 1));
      wd = $urandom;
      model(1, 1'b1, a, wd, 4'hF, e_rd, e_er);
      do_txn(1'b1, a, wd, 4'hF, 0, rd, er, lat, pok, tmo);
      checks++; if (lat !== 1 || er !== 1'b0 || !pok) begin errors++; $display("FAIL b2b_wr #%0d got lat=%0d err=%b idle=%b exp lat=1 err=0 idle=1", i, lat, er, pok); end
      model(1, 1'b0, a, 32'h0, 4'h0, e_rd, e_er);
      do_txn(1'b0, a, 32'h0, 4'h0, 0, rd, er, lat, pok, tmo);
      checks++; if (lat !== 1 || rd !== e_rd || rd !== wd) begin errors++; $display("FAIL b2b_rd #%0d got lat=%0d rd=%h exp lat=1 rd=%h", i, lat, rd, wd); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enable();
    test_errors();
    test_hold();
    test_reset_mid();
    test_fill(0);
    test_fill(1);
    test_random(0, 60);
    test_random(1, 60);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the CPU data-memory port.
- Accepts one read or write request at a time over a valid/ready request channel.
- Inserts a programmable number of wait states, then returns read data and status over a valid/ready response channel.
- Replaces the zero-latency data memory when the multi-cycle memory-system model is used.

Parameters:
DEPTH, 64, number of 32-bit words stored; power of two, 4..1024
WAIT_CYCLES, 2, extra wait states between accept and commit; 0..15
ADDR_BASE, 32'h0000_0000, byte address of word 0; word-aligned

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  32  byte address
req_wdata  in  32  write data
req_be  in  4  byte enables; bit i covers wdata[8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  initiator takes the response
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_err  out  1  misaligned or out-of-range access

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- Reset does not clear storage contents.
- FSM states:
  - IDLE: req_ready=1. On req_valid & req_ready, latch we, addr, wdata and be; load counter with WAIT_CYCLES; go to BUSY.
  - BUSY: req_ready=0. If counter != 0, decrement. If counter == 0, the next edge performs the access, captures rsp_rdata/rsp_err, and goes to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable. On rsp_ready, go to IDLE.
- Latency: accept on edge N gives rsp_valid high after edge N+WAIT_CYCLES+1.
- Throughput: at most one request per WAIT_CYCLES+3 cycles. No request is accepted while in BUSY or RESP.
- Word index = (addr - ADDR_BASE) >> 2, computed in 32-bit unsigned arithmetic; wrap-around counts as out of range.
- Error when addr[1:0] != 0 or word index >= DEPTH. On error: no storage change, rsp_rdata=0, rsp_err=1.
- Write: only bytes with be=1 are updated, on the commit edge. be=4'b0000 is a legal no-op with rsp_err=0.
- Write response: rsp_rdata=0.
- Read: rsp_rdata is the full word at commit time; be is ignored for reads.
- Ordering is strict: a read following a write to the same word returns the written data.
- rsp_ready held high before RESP has no effect. rsp_ready high in RESP returns to IDLE in one cycle; a new request can be accepted on the following cycle.
- Inputs are sampled only on the accept edge; changes to req_* during BUSY or RESP are ignored.
- Reset mid-operation:
  - Returns immediately to IDLE and drops any pending response.
  - A write not yet committed is lost.
  - A write committed before reset persists.

Decomposition:
- Package mem_if_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - BYTE_LANES=4 and WORD_BYTES=4;
  - the width of the wait-counter field.
- Sub-module dmem_bank:
  - DEPTH x 32 storage with byte-enable write and synchronous read on one port;
  - inputs en, we, be, idx, wdata; output rdata.
  - The responder FSM drives en only on the commit edge.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> write response err=0, rdata=0; read response rdata=0xDEADBEEF. With WAIT_CYCLES=2, rsp_valid rises exactly 3 edges after accept.
- Write 0x11223344 to 0x20 (be=F), then 0xAABBCCDD with be=4'b0101, then read 0x20 -> rdata=0x11BB33DD.
- Read 0x13 (misaligned) and read ADDR_BASE+4*DEPTH -> both give rsp_err=1, rdata=0. A following read of 0x10 still returns its prior contents.
- Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid -> rsp_valid, rdata and err stay stable; req_ready=0 and no second accept occur; one cycle after rsp_ready=1, req_ready=1.
- Assert rst_n=0 during BUSY of a write of 0x55 to 0x30 (old value 0x0) -> rsp_valid=0 and req_ready=1 immediately; a later read of 0x30 returns 0x0.
- Re-run with WAIT_CYCLES=0: back-to-back read/write pairs -> rsp_valid one edge after accept, data correct.
